// File: rtl/game_datapath_gen.sv
// Guessing-game datapath: setup, prescaled timer, round counter, LFSR secret, score, key edge, display.
// Latency: state updates on the next clock_50 edge; hex and win 1 cycle later; end_user 3 cycles after press.
// No backpressure: enables from the control FSM act every cycle; HEX_ACTIVE_LOW_EN inverts hex polarity.
module game_datapath_gen #(
   parameter int SW_W     = 8,
   parameter int N_HEX    = 6,
   parameter int TICK_DIV = 50_000_000,
   parameter int TIME_MAX = 10,
   parameter int ROUNDS   = 16,
   parameter int PTS_W    = 8,
   parameter int WIN_PTS  = 10
) (
   input  logic                 clock_50,
   input  logic                 r,
   input  logic                 r_time,
   input  logic [3:0]           key,
   input  logic [SW_W-1:0]      switch,
   input  logic                 e_setup,
   input  logic                 e_time,
   input  logic                 e_round,
   input  logic                 e_pts,
   input  logic                 sel,
   output logic [7*N_HEX-1:0]   hex,
   output logic [3:0]           leds,
   output logic                 end_fpga,
   output logic                 end_user,
   output logic                 end_time,
   output logic                 win,
   output logic                 match
);
   localparam int             PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [3:0]     TIME_TOP   = 4'(TIME_MAX);
   localparam logic [3:0]     ROUND_TOP  = 4'(ROUNDS - 1);
   localparam logic [PTS_W-1:0] PTS_TOP  = '1;
   localparam logic [PTS_W-1:0] WIN_THR  = PTS_W'(WIN_PTS);
`ifdef HEX_ACTIVE_LOW_EN
   localparam logic [7*N_HEX-1:0] HEX_INV = '1;
`else
   localparam logic [7*N_HEX-1:0] HEX_INV = '0;
`endif

   // Letter glyphs, bit6 = segment a .. bit0 = segment g
   localparam logic [6:0] G_U = 7'b0111110, G_S = 7'b1011011, G_E = 7'b1001111;
   localparam logic [6:0] G_R = 7'b0000101, G_F = 7'b1000111, G_P = 7'b1100111;
   localparam logic [6:0] G_G = 7'b1011110, G_A = 7'b1110111, G_L = 7'b0001110;
   localparam logic [6:0] G_T = 7'b0001111;

   logic [SW_W-1:0]   setup;
   logic [SW_W-3:0]   secret;
   logic [15:0]       lfsr;
   logic [PW-1:0]     presc;
   logic [3:0]        game_time;
   logic [3:0]        round_cnt;
   logic [PTS_W-1:0]  points;
   logic              key_s1, key_s2, key_s3;
   logic [1:0]        level;
   logic [2:0]        pts_add;
   logic [PTS_W:0]    pts_sum;
   logic [PTS_W+7:0]  pts_ext;
   logic [7:0]        pts8;
   logic [7*N_HEX-1:0] disp_next;
   logic              unused_bits;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'h0: seg7 = 7'b1111110;  4'h1: seg7 = 7'b0110000;
         4'h2: seg7 = 7'b1101101;  4'h3: seg7 = 7'b1111001;
         4'h4: seg7 = 7'b0110011;  4'h5: seg7 = 7'b1011011;
         4'h6: seg7 = 7'b1011111;  4'h7: seg7 = 7'b1110000;
         4'h8: seg7 = 7'b1111111;  4'h9: seg7 = 7'b1111011;
         4'hA: seg7 = 7'b1110111;  4'hB: seg7 = 7'b0011111;
         4'hC: seg7 = 7'b1001110;  4'hD: seg7 = 7'b0111101;
         4'hE: seg7 = 7'b1001111;  default: seg7 = 7'b1000111;
      endcase
   endfunction

   assign level    = setup[SW_W-1:SW_W-2];
   assign match    = (switch[SW_W-3:0] == secret);
   assign end_fpga = (round_cnt == ROUND_TOP);
   assign leds     = round_cnt;
   assign pts_add  = match ? ({1'b0, level} + 3'd1) : 3'd0;
   assign pts_sum  = {1'b0, points} + {{(PTS_W-2){1'b0}}, pts_add};
   assign pts_ext  = {8'd0, points};
   assign pts8     = pts_ext[7:0];
   assign unused_bits = ^{key[3:1], setup[SW_W-3:0], pts_ext[PTS_W+7:8]};

   // Setup register, free-running LFSR and secret capture on round advance
   always_ff @(posedge clock_50) begin
      if (r) begin
         setup  <= '0;
         secret <= '0;
         lfsr   <= 16'd1;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         if (e_setup) setup  <= switch;
         if (e_round) secret <= lfsr[SW_W-3:0];
      end
   end

   // Prescaled game timer; r_time clears even when e_time is high
   always_ff @(posedge clock_50) begin
      if (r || r_time) begin
         presc     <= '0;
         game_time <= '0;
      end else if (e_time) begin
         if (presc == PRESC_LAST) begin
            presc <= '0;
            if (game_time != TIME_TOP) game_time <= game_time + 4'd1;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   // Round counter, saturating score and the registered status flags
   always_ff @(posedge clock_50) begin
      if (r) begin
         round_cnt <= '0;
         points    <= '0;
         end_time  <= 1'b0;
         win       <= 1'b0;
      end else begin
         if (e_round && round_cnt != ROUND_TOP) round_cnt <= round_cnt + 4'd1;
         if (e_pts) points <= pts_sum[PTS_W] ? PTS_TOP : pts_sum[PTS_W-1:0];
         end_time <= (game_time == TIME_TOP);
         win      <= (points >= WIN_THR);
      end
   end

   // Submit key synchroniser; one registered pulse on the press (falling) edge
   always_ff @(posedge clock_50) begin
      if (r) begin
         key_s1   <= 1'b0;
         key_s2   <= 1'b0;
         key_s3   <= 1'b0;
         end_user <= 1'b0;
      end else begin
         key_s1   <= key[0];
         key_s2   <= key_s1;
         key_s3   <= key_s2;
         end_user <= key_s3 & ~key_s2;
      end
   end

   // Display content for the selected view; digits above 5 stay blank
   always_comb begin
      disp_next = '0;
      if (!sel) begin
         disp_next[35 +: 7] = G_L;
         disp_next[28 +: 7] = seg7({2'b00, level});
         disp_next[21 +: 7] = G_T;
         disp_next[14 +: 7] = seg7(game_time);
         disp_next[7  +: 7] = G_R;
         disp_next[0  +: 7] = seg7(round_cnt);
      end else begin
         disp_next[35 +: 7] = win ? G_U : G_F;
         disp_next[28 +: 7] = win ? G_S : G_P;
         disp_next[21 +: 7] = win ? G_E : G_G;
         disp_next[14 +: 7] = win ? G_R : G_A;
         disp_next[7  +: 7] = seg7(pts8[7:4]);
         disp_next[0  +: 7] = seg7(pts8[3:0]);
      end
   end

   // Display output register; polarity applied here so blank follows the board type
   always_ff @(posedge clock_50) begin
      if (r) hex <= HEX_INV;
      else   hex <= disp_next ^ HEX_INV;
   end
endmodule
